// File: rtl/ucaspian_pkg.sv
// Shared constants and types for the uCaspian host TX path.
package ucaspian_pkg;

    localparam int unsigned NUM_TX_SRC = 4;

    localparam int unsigned SRC_ACK    = 0;
    localparam int unsigned SRC_FIRE   = 1;
    localparam int unsigned SRC_TIME   = 2;
    localparam int unsigned SRC_METRIC = 3;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            int unsigned j;
            j = (32'(ptr) + i) % NUM_REQ;
            if (!any && req[IDX_W'(j)]) begin
                any              = 1'b1;
                gnt[IDX_W'(j)]   = 1'b1;
                idx              = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/tx_packet_arbiter.sv
// Packet-level arbiter merging per-source byte streams onto the host TX channel
// through a registered one-byte output stage.
module tx_packet_arbiter
    import ucaspian_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_TX_SRC,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned PRIO0   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC*8-1:0]       src_data,
    input  logic [NUM_SRC-1:0]         src_vld,
    input  logic [NUM_SRC-1:0]         src_last,
    output logic [NUM_SRC-1:0]         src_rdy,
    output logic [7:0]                 tx_data,
    output logic                       tx_vld,
    input  logic                       tx_rdy,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx,
    output logic                       busy,
    output logic                       len_err
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_vld_q, tx_vld_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               len_err_q, len_err_d;

    logic [NUM_SRC-1:0] rr_gnt;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;

    logic [NUM_SRC-1:0] onehot;
    logic [IDX_W-1:0]   sel;
    logic               req;
    logic               can_accept;
    logic               accept;
    logic               at_max;
    logic               pkt_end;

    rr_pick #(
        .NUM_REQ (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req (src_vld),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    always_comb begin
        onehot = '0;
        sel    = grant_q;
        req    = 1'b0;
        // A locked packet is never preempted; the source-0 override only applies when idle.
        if (state_q == StLocked) begin
            onehot[grant_q] = 1'b1;
            sel             = grant_q;
            req             = src_vld[grant_q];
        end else if (PRIO0 != 0 && src_vld[SRC_ACK]) begin
            onehot[SRC_ACK] = 1'b1;
            sel             = IDX_W'(SRC_ACK);
            req             = 1'b1;
        end else begin
            onehot = rr_gnt;
            sel    = rr_idx;
            req    = rr_any;
        end

        can_accept = !tx_vld_q || tx_rdy;
        src_rdy    = (can_accept && reset) ? onehot : '0;
        accept     = can_accept && req && reset;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        tx_vld_d  = tx_vld_q;
        tx_data_d = tx_data_q;
        len_err_d = len_err_q;

        at_max  = (cnt_q == CNT_W'(MAX_LEN - 1));
        pkt_end = src_last[sel] || at_max;

        if (accept) begin
            tx_vld_d  = 1'b1;
            tx_data_d = src_data[{sel, 3'b000} +: 8];
            if (state_q == StIdle) begin
                grant_d = sel;
            end
            if (pkt_end) begin
                state_d  = StIdle;
                cnt_d    = '0;
                rr_ptr_d = sel;
                if (!src_last[sel]) begin
                    len_err_d = 1'b1;
                end
            end else begin
                state_d = StLocked;
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (tx_rdy) begin
            tx_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            rr_ptr_q  <= IDX_W'(NUM_SRC - 1);
            cnt_q     <= '0;
            tx_vld_q  <= 1'b0;
            tx_data_q <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            tx_vld_q  <= tx_vld_d;
            tx_data_q <= tx_data_d;
            len_err_q <= len_err_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_vld    = tx_vld_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q == StLocked);
    assign len_err   = len_err_q;

endmodule

// File: doc/tx_packet_arbiter.md
TX_PACKET_ARBITER -- requirements
Module: tx_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of packet sources (0=ack, 1=fire, 2=time, 3=metric).
REQ-002 SHALL have parameter MAX_LEN, default 8, maximum bytes per packet before forced termination.
REQ-003 SHALL have parameter PRIO0, default 1, when 1 source 0 wins any idle arbitration regardless of round-robin pointer.
REQ-004 SHALL have port clk input 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port reset input 1, asynchronous active-low reset.
REQ-006 SHALL have port src_data input NUM_SRC x 8, per-source packet byte.
REQ-007 SHALL have port src_vld input NUM_SRC, per-source byte valid.
REQ-008 SHALL have port src_last input NUM_SRC, marks final byte of the packet.
REQ-009 SHALL have port src_rdy output NUM_SRC, byte accepted when src_vld and src_rdy both high.
REQ-010 SHALL have port tx_data output 8, byte to host TX channel.
REQ-011 SHALL have port tx_vld output 1, tx_data valid.
REQ-012 SHALL have port tx_rdy input 1, host consumes byte when tx_vld and tx_rdy both high.
REQ-013 SHALL have port grant_idx output clog2(NUM_SRC), currently locked source.
REQ-014 SHALL have port busy output 1, high while a packet is locked.
REQ-015 SHALL have port len_err output 1, sticky flag, set on forced termination.

Function
REQ-016 SHALL use a registered one-byte output stage; byte accepted in cycle N appears on tx_data in cycle N+1.
REQ-017 Output stage SHALL accept a byte when empty or being drained in the same cycle (tx_vld and tx_rdy); full throughput one byte per cycle.
REQ-018 tx_data SHALL stay stable while tx_vld high and tx_rdy low.
REQ-019 At most one src_rdy bit SHALL be high in any cycle; src_rdy SHALL be low for non-granted sources.
REQ-020 States: IDLE, LOCKED.
REQ-021 IDLE: winner chosen combinationally among src_vld -- source 0 if PRIO0 and src_vld[0], else first valid source searching from rr_ptr+1 upward, wrapping modulo NUM_SRC; winner's first byte accepted same cycle if output stage can accept.
REQ-022 IDLE to LOCKED on accepting a first byte without src_last; grant_idx latched to winner; single-byte packet (last on first byte) stays IDLE.
REQ-023 LOCKED: only grant_idx source served; other sources' src_vld ignored until packet ends; packet never interleaved.
REQ-024 LOCKED to IDLE on accepting a byte with src_last; rr_ptr updated to grant_idx at every packet end (including single-byte and forced).
REQ-025 Byte counter 0..MAX_LEN counts accepted bytes of current packet, cleared at packet end.
REQ-026 If MAX_LEN bytes accepted without src_last, arbiter SHALL return to IDLE, set len_err, update rr_ptr; remaining source bytes compete as a new packet.
REQ-027 Source dropping src_vld mid-packet SHALL hold LOCKED, stalling tx with tx_vld low after drain; no timeout.
REQ-028 PRIO0 override SHALL apply only in IDLE, never preempting a locked packet.
REQ-029 len_err SHALL clear only on reset.

Reset
REQ-030 Reset asserted SHALL immediately force: state IDLE, tx_vld 0, tx_data 0, src_rdy 0, grant_idx 0, busy 0, len_err 0, rr_ptr NUM_SRC-1, byte counter 0.
REQ-031 Reset mid-packet SHALL discard the held byte and the partial packet; no recovery of the partial packet after release.
REQ-032 First arbitration after release SHALL occur in the first clock edge with reset high.

Structure
REQ-033 Shared package ucaspian_pkg SHALL hold NUM_TX_SRC, source index constants SRC_ACK/SRC_FIRE/SRC_TIME/SRC_METRIC, and the arbiter state enum.
REQ-034 Round-robin search SHALL be a sub-module rr_pick (inputs: request vector, pointer; outputs: one-hot grant, index, any).

Verification
REQ-035 Sources 1 and 3 each present 3-byte packets simultaneously, tx_rdy=1 -> six bytes on tx, all source-1 bytes then source-3 bytes, no interleave, rr_ptr=3.
REQ-036 Source 2 mid-packet (byte 2 of 4) and source 0 raises vld, PRIO0=1 -> source 2 completes all 4 bytes, then source 0 packet follows.
REQ-037 tx_rdy low for 5 cycles after byte 0xA5 presented -> tx_data holds 0xA5, tx_vld high, all src_rdy low during stall.
REQ-038 Source 1 sends 10 bytes without last, MAX_LEN=8 -> 8 bytes forwarded, len_err=1, arbiter idle, bytes 9-10 sent as new packet.
REQ-039 Reset low during byte 2 of a 4-byte packet -> tx_vld 0 same cycle, busy 0, grant_idx 0; after release next requester arbitrates fresh.
REQ-040 All four sources request single-byte packets continuously, PRIO0=0 -> grant order 0,1,2,3,0 repeating, one byte per cycle.
